kyber_bram_sequencer: RTL and testbench

KYBER_BRAM_SEQUENCER -- requirements
Module: kyber_bram_sequencer

---
 rtl/kyber_bram_sequencer_if.sv | 40 ++++
 rtl/kyber_bram_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_kyber_bram_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_bram_sequencer_if.sv
// Kyber BRAM sequencer bus: host control, BRAM port B, core load/store streams.
interface kyber_bram_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 128
);
    logic              start;
    logic [1:0]        mode;
    logic              busy;
    logic              done;
    logic              err;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic              core_start;
    logic              core_finish;
    logic              ld_valid;
    logic [2:0]        ld_sel;
    logic [5:0]        ld_idx;
    logic [DATA_W-1:0] ld_data;
    logic              st_req;
    logic [1:0]        st_sel;
    logic [5:0]        st_idx;
    logic [DATA_W-1:0] st_data;

    modport master (
        output start, mode, bram_rdata, core_finish, st_data,
        input  busy, done, err, bram_en, bram_we, bram_addr, bram_wdata,
        input  core_start, ld_valid, ld_sel, ld_idx, ld_data,
        input  st_req, st_sel, st_idx
    );

    modport slave (
        input  start, mode, bram_rdata, core_finish, st_data,
        output busy, done, err, bram_en, bram_we, bram_addr, bram_wdata,
        output core_start, ld_valid, ld_sel, ld_idx, ld_data,
        output st_req, st_sel, st_idx
    );
endinterface

// File: rtl/kyber_bram_sequencer.sv
// Kyber BRAM port-B sequencer: streams operands to the core, runs it, writes results back.
// Optional RUN-phase watchdog enabled by defining KYBER_SEQ_WATCHDOG_EN.
module kyber_bram_sequencer #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 128,
    parameter int WDOG_CYCLES = 1048576
) (
    input logic                   clk,
    input logic                   rst,
    kyber_bram_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_STORE, S_DONE
    } state_t;

    if (WDOG_CYCLES < 1 || ADDR_W < 9) begin : g_cfg_bad
        $error("kyber_bram_sequencer: unsupported parameters");
    end

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [6:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, done_q, err_q;
    logic              en_q, we_q, cs_q, ldv_q, st_req_q;
    logic [2:0]        ld_sel_q;
    logic [5:0]        ld_idx_q, st_idx_q;
    logic [1:0]        st_sel_q;
    logic [DATA_W-1:0] wdata_d, ld_data_d;
`ifdef KYBER_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0]    wdog_q;
`endif

    // Each mode touches one contiguous address run, so base + count covers it.
    function automatic logic [ADDR_W-1:0] ld_base(input logic [1:0] m);
        case (m)
            2'd0:    return ADDR_W'(52);
            2'd1:    return ADDR_W'(0);
            default: return ADDR_W'(54);
        endcase
    endfunction

    function automatic logic [6:0] ld_len(input logic [1:0] m);
        case (m)
            2'd0:    return 7'd2;
            2'd1:    return 7'd54;
            default: return 7'd96;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] st_base(input logic [1:0] m);
        case (m)
            2'd0:    return ADDR_W'(256);
            2'd1:    return ADDR_W'(354);
            default: return ADDR_W'(402);
        endcase
    endfunction

    function automatic logic [6:0] st_len(input logic [1:0] m);
        case (m)
            2'd0:    return 7'd98;
            2'd1:    return 7'd48;
            default: return 7'd2;
        endcase
    endfunction

    function automatic logic [8:0] ld_map(input logic [ADDR_W-1:0] a);
        if (a < ADDR_W'(50))       return {3'd0, 6'(a)};
        else if (a < ADDR_W'(52))  return {3'd1, 6'(a - ADDR_W'(50))};
        else if (a < ADDR_W'(54))  return {3'd2, 6'(a - ADDR_W'(52))};
        else if (a < ADDR_W'(102)) return {3'd3, 6'(a - ADDR_W'(54))};
        else                       return {3'd4, 6'(a - ADDR_W'(102))};
    endfunction

    function automatic logic [7:0] st_map(input logic [ADDR_W-1:0] a);
        if (a < ADDR_W'(306))      return {2'd0, 6'(a - ADDR_W'(256))};
        else if (a < ADDR_W'(354)) return {2'd1, 6'(a - ADDR_W'(306))};
        else if (a < ADDR_W'(402)) return {2'd2, 6'(a - ADDR_W'(354))};
        else                       return {2'd3, 6'(a - ADDR_W'(402))};
    endfunction

    always_comb begin
        cnt_d     = cnt_q + 7'd1;
        addr_d    = addr_q + ADDR_W'(1);
        wdata_d   = st_req_q ? bus.st_data : '0;
        ld_data_d = ldv_q ? bus.bram_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            cs_q     <= 1'b0;
            ldv_q    <= 1'b0;
            ld_sel_q <= '0;
            ld_idx_q <= '0;
            st_req_q <= 1'b0;
            st_sel_q <= '0;
            st_idx_q <= '0;
`ifdef KYBER_SEQ_WATCHDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    err_q <= 1'b0;
                    if (bus.start && bus.mode == 2'd3) begin
                        err_q <= 1'b1;
                    end else if (bus.start) begin
                        state_q <= S_LOAD;
                        mode_q  <= bus.mode;
                        busy_q  <= 1'b1;
                        en_q    <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= ld_base(bus.mode);
                        cnt_q   <= '0;
`ifdef KYBER_SEQ_WATCHDOG_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    // A word read in cycle k is presented in cycle k+1.
                    cnt_q <= cnt_d;
                    ldv_q <= en_q;
                    {ld_sel_q, ld_idx_q} <= ld_map(addr_q);
                    if (cnt_d >= ld_len(mode_q)) en_q <= 1'b0;
                    else addr_q <= addr_d;
                    if (cnt_q == ld_len(mode_q)) begin
                        state_q <= S_RUN;
                        cs_q    <= 1'b1;
                        ldv_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    cs_q <= 1'b0;
                    if (!cs_q && bus.core_finish) begin
                        state_q  <= S_STORE;
                        en_q     <= 1'b1;
                        we_q     <= 1'b1;
                        st_req_q <= 1'b1;
                        addr_q   <= st_base(mode_q);
                        {st_sel_q, st_idx_q} <= st_map(st_base(mode_q));
                        cnt_q    <= '0;
                    end
`ifdef KYBER_SEQ_WATCHDOG_EN
                    else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
`endif
                end
                S_STORE: begin
                    if (cnt_q == st_len(mode_q) - 7'd1) begin
                        state_q  <= S_DONE;
                        en_q     <= 1'b0;
                        we_q     <= 1'b0;
                        st_req_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_d;
                        addr_q <= addr_d;
                        {st_sel_q, st_idx_q} <= st_map(addr_d);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.bram_en    = en_q;
    assign bus.bram_we    = we_q;
    assign bus.bram_addr  = addr_q;
    assign bus.bram_wdata = wdata_d;
    assign bus.core_start = cs_q;
    assign bus.ld_valid   = ldv_q;
    assign bus.ld_sel     = ld_sel_q;
    assign bus.ld_idx     = ld_idx_q;
    assign bus.ld_data    = ld_data_d;
    assign bus.st_req     = st_req_q;
    assign bus.st_sel     = st_sel_q;
    assign bus.st_idx     = st_idx_q;
endmodule

// File: tb/tb_kyber_bram_sequencer.sv
// Scoreboard bench for kyber_bram_sequencer: segment-level model, BRAM and core stand-ins.
module tb_kyber_bram_sequencer;
    localparam int AW = 9;
    localparam int DW = 128;
    localparam int LD_BASE [5] = '{0, 50, 52, 54, 102};
    localparam int LD_LEN  [5] = '{50, 2, 2, 48, 48};
    localparam int ST_BASE [4] = '{256, 306, 354, 402};
    localparam int ST_LEN  [4] = '{50, 48, 48, 2};

    typedef struct {
        int sel;
        int idx;
        int addr;
        logic [DW-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kyber_bram_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    kyber_bram_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [DW-1:0] mem [0:511];
    int unsigned salt;
    int n_chk = 0, n_pass = 0;
    int cyc = 0, fin_delay = 1, spur_req = 0, spur_ack = 0;
    int wr_seen = 0, done_seen = 0, err_seen = 0, cs_seen = 0, exp_cs = 0;
    int cs_cyc = 0, err_cyc = 0;
    int exp_rd[$];
    int rd_cyc[$];
    int exp_ev[$];
    item_t exp_ld[$];
    item_t exp_wr[$];

    function automatic logic [DW-1:0] gen(input logic [1:0] s, input logic [5:0] i);
        return {salt, 32'(s), 32'(i), salt ^ {26'h0, i}};
    endfunction

    assign bus.st_data = gen(bus.st_sel, bus.st_idx);

    always @(posedge clk)
        if (bus.bram_en && !bus.bram_we) bus.bram_rdata <= mem[bus.bram_addr];

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic unexp(input string nm, input int v);
        n_chk++;
        $display("FAIL %s: unexpected activity, value %0d (t=%0t)", nm, v, $time);
    endtask

    // Reference model: expand the mode's segment lists into expected transfers.
    task automatic push_op(input int m, input bit no_store);
        int lsegs[$];
        int ssegs[$];
        int a;
        if (m == 3) begin
            exp_ev.push_back(1);
            return;
        end
        case (m)
            0: begin lsegs = '{2}; ssegs = '{0, 1}; end
            1: begin lsegs = '{0, 1, 2}; ssegs = '{2}; end
            default: begin lsegs = '{3, 4}; ssegs = '{3}; end
        endcase
        foreach (lsegs[k])
            for (int i = 0; i < LD_LEN[lsegs[k]]; i++) begin
                a = LD_BASE[lsegs[k]] + i;
                exp_rd.push_back(a);
                exp_ld.push_back('{lsegs[k], i, a, mem[a]});
            end
        if (!no_store)
            foreach (ssegs[k])
                for (int i = 0; i < ST_LEN[ssegs[k]]; i++)
                    exp_wr.push_back('{ssegs[k], i, ST_BASE[ssegs[k]] + i,
                                       gen(2'(ssegs[k]), 6'(i))});
        exp_ev.push_back(no_store ? 1 : 0);
        exp_cs++;
    endtask

    task automatic flush();
        exp_rd.delete();
        rd_cyc.delete();
        exp_ev.delete();
        exp_ld.delete();
        exp_wr.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.core_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.core_start && fin_delay > 0) begin
                repeat (fin_delay) @(negedge clk);
                bus.core_finish = 1'b1;
                @(negedge clk);
                bus.core_finish = 1'b0;
            end else if (spur_req != spur_ack) begin
                bus.core_finish = 1'b1;
                @(negedge clk);
                bus.core_finish = 1'b0;
                spur_ack++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows activity.
    initial begin
        int ma;
        item_t mi;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.bram_en && !bus.bram_we) begin
                    if (exp_rd.size() == 0) unexp("rd_extra", int'(bus.bram_addr));
                    else begin
                        ma = exp_rd.pop_front();
                        chki("rd_addr", int'(bus.bram_addr), ma);
                        rd_cyc.push_back(cyc);
                    end
                end
                if (bus.ld_valid) begin
                    if (exp_ld.size() == 0 || rd_cyc.size() == 0)
                        unexp("ld_extra", int'(bus.ld_idx));
                    else begin
                        mi = exp_ld.pop_front();
                        ma = rd_cyc.pop_front();
                        chki("ld_sel", int'(bus.ld_sel), mi.sel);
                        chki("ld_idx", int'(bus.ld_idx), mi.idx);
                        chkd("ld_data", bus.ld_data, mi.data);
                        chki("ld_lat", cyc, ma + 1);
                    end
                end
                if (bus.bram_en && bus.bram_we) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) unexp("wr_extra", int'(bus.bram_addr));
                    else begin
                        mi = exp_wr.pop_front();
                        chki("wr_addr", int'(bus.bram_addr), mi.addr);
                        chki("st_sel", int'(bus.st_sel), mi.sel);
                        chki("st_idx", int'(bus.st_idx), mi.idx);
                        chkd("wr_data", bus.bram_wdata, mi.data);
                        chki("st_req", int'(bus.st_req), 1);
                    end
                end else if (bus.st_req) unexp("st_req_stray", int'(bus.st_idx));
                if (bus.core_start) begin
                    cs_seen++;
                    cs_cyc = cyc;
                end
                if (bus.done) begin
                    done_seen++;
                    if (exp_ev.size() == 0) unexp("done_extra", cyc);
                    else chki("done_ev", 0, exp_ev.pop_front());
                end
                if (bus.err) begin
                    err_seen++;
                    err_cyc = cyc;
                    if (exp_ev.size() == 0) unexp("err_extra", cyc);
                    else chki("err_ev", 1, exp_ev.pop_front());
                end
            end
        end
    end

    task automatic chk_outs_zero(input string nm);
        logic any;
        any = bus.busy | bus.done | bus.err | bus.bram_en | bus.bram_we
            | (|bus.bram_addr) | (|bus.bram_wdata) | bus.core_start
            | bus.ld_valid | (|bus.ld_sel) | (|bus.ld_idx) | (|bus.ld_data)
            | bus.st_req | (|bus.st_sel) | (|bus.st_idx);
        chki({nm, "_all"}, int'(any), 0);
        chki({nm, "_busy"}, int'(bus.busy), 0);
        chki({nm, "_en"}, int'(bus.bram_en), 0);
        chki({nm, "_streq"}, int'(bus.st_req), 0);
    endtask

    task automatic wait_ev();
        int t = 0;
        while (exp_ev.size() != 0 && t < 3000) begin
            @(negedge clk);
            #1;
            bus.mode = 2'($urandom_range(0, 3));
            t++;
        end
        if (t >= 3000) begin
            unexp("timeout", t);
            flush();
        end
    endtask

    task automatic run_op(input int m, input int d, input bit mid);
        fin_delay = d;
        @(negedge clk);
        #1;
        push_op(m, d == 0);
        bus.start = 1'b1;
        bus.mode  = 2'(m);
        @(posedge clk);
        #1;
        chki("busy_acc", int'(bus.busy), (m != 3) ? 1 : 0);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        if (mid && m != 3) begin
            repeat (8) @(negedge clk);
            #1;
            bus.start = 1'b1;
            bus.mode  = 2'($urandom_range(0, 3));
            @(negedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_ev();
        @(posedge clk);
        #1;
        chki("busy_end", int'(bus.busy), 0);
        chki("ld_left", exp_ld.size(), 0);
        chki("wr_left", exp_wr.size(), 0);
    endtask

    initial begin
        int w0, d0, e0, t;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        salt = $urandom;
        for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        #22;
        chk_outs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(1, 100, 1'b0);
        run_op(0, $urandom_range(1, 10), 1'b0);
        run_op(2, $urandom_range(1, 10), 1'b1);
        run_op(3, 1, 1'b0);

        spur_req++;
        repeat (4) @(negedge clk);
        #1;
        chki("spur_busy", int'(bus.busy), 0);

        for (int k = 0; k < 6; k++)
            run_op($urandom_range(0, 3), $urandom_range(1, 12), 1'(k % 2));

        // Abort during STORE at word 20.
        w0 = wr_seen;
        fin_delay = $urandom_range(1, 8);
        @(negedge clk);
        #1;
        push_op(1, 1'b0);
        bus.start = 1'b1;
        bus.mode  = 2'd1;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        t = 0;
        while (wr_seen < w0 + 20 && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 500) unexp("rst_wait", t);
        d0 = done_seen;
        e0 = err_seen;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_outs_zero("rst_mid");
        flush();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chki("rst_no_done", done_seen, d0);
        chki("rst_no_err", err_seen, e0);
        run_op(1, 100, 1'b0);

`ifdef KYBER_SEQ_WATCHDOG_EN
        run_op(1, 0, 1'b0);
        chki("wdog_lat", err_cyc - cs_cyc, 16);
`endif

        repeat (4) @(negedge clk);
        chki("rd_left", exp_rd.size(), 0);
        chki("ev_left", exp_ev.size(), 0);
        chki("core_starts", cs_seen, exp_cs);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
